// File: rtl/mc_apb_cfg_mch.sv
// mc_apb_cfg_mch: multi-channel APB configuration bank for the memory controller.
// Shadow/active timing per channel, commit handshake, W1C status, IRQ mask, version.
module mc_apb_cfg_mch #(
    parameter int          APB_ADDR_WIDTH = 16,
    parameter int          APB_DATA_WIDTH = 32,
    parameter int          NUM_CH         = 2,
    parameter logic [31:0] VERSION        = 32'h0002_0000
) (
    input  logic                      apb_pclk,
    input  logic                      apb_prst,
    input  logic                      apb_psel,
    input  logic                      apb_penable,
    input  logic                      apb_pwrite,
    input  logic [APB_ADDR_WIDTH-1:0] apb_paddr,
    input  logic [APB_DATA_WIDTH-1:0] apb_pwdata,
    output logic [APB_DATA_WIDTH-1:0] apb_prdata,
    output logic                      apb_pready,
    output logic                      apb_pslverr,
    input  logic [NUM_CH-1:0]         mc_idle,
    input  logic [NUM_CH-1:0]         mc_err_pulse,
    output logic [NUM_CH-1:0]         mc_en,
    output logic [8*NUM_CH-1:0]       mc_trc_cfg,
    output logic [8*NUM_CH-1:0]       mc_tras_cfg,
    output logic [8*NUM_CH-1:0]       mc_trp_cfg,
    output logic [8*NUM_CH-1:0]       mc_trcd_cfg,
    output logic [8*NUM_CH-1:0]       mc_twr_cfg,
    output logic [8*NUM_CH-1:0]       mc_trtp_cfg,
    output logic [28*NUM_CH-1:0]      mc_rf_start_time_cfg,
    output logic [28*NUM_CH-1:0]      mc_rf_period_time_cfg,
    output logic [NUM_CH-1:0]         mc_cfg_updated,
    output logic                      mc_irq
);

    localparam int AW = APB_ADDR_WIDTH;

    typedef struct packed {
        logic [7:0]  trc;
        logic [7:0]  tras;
        logic [7:0]  trp;
        logic [7:0]  trcd;
        logic [7:0]  twr;
        logic [7:0]  trtp;
        logic [27:0] rf_start;
        logic [27:0] rf_period;
    } tim_t;

    localparam tim_t TIM_RST = '{
        trc:       8'd22,
        tras:      8'd16,
        trp:       8'd6,
        trcd:      8'd7,
        twr:       8'd6,
        trtp:      8'd4,
        rf_start:  28'hFFF_FFFF,
        rf_period: 28'h16E_3600
    };

    tim_t sh_q [NUM_CH];
    tim_t ac_q [NUM_CH];

    logic [NUM_CH-1:0] mc_en_q;
    logic [NUM_CH-1:0] pending_q;
    logic [NUM_CH-1:0] status_q;
    logic [NUM_CH-1:0] mask_q;

    logic              aligned;
    logic              glb_ok;
    logic              is_ver;
    logic [NUM_CH-1:0] ch_hit;
    logic              map_ok;
    logic              acc_err;
    logic              wr_en;
    logic              rd_cap;
    logic [2:0]        reg_sel;
    logic [APB_DATA_WIDTH-1:0] rd_val;

    logic [NUM_CH-1:0] commit_set;
    logic [NUM_CH-1:0] status_clr;
    logic [NUM_CH-1:0] status_nx;
    logic [NUM_CH-1:0] apply;

    assign reg_sel = apb_paddr[4:2];
    assign aligned = (apb_paddr[1:0] == 2'b00);

    // Address decode: global window at 0x000, channel windows at 0x100 + 0x20*c.
    always_comb begin
        glb_ok = aligned && (apb_paddr[AW-1:5] == '0) && (reg_sel <= 3'd4);
        is_ver = glb_ok && (reg_sel == 3'd4);
        ch_hit = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            ch_hit[c] = aligned && !apb_paddr[4] &&
                        (apb_paddr[AW-1:5] == (AW-5)'(8 + c));
        end
        map_ok  = glb_ok || (|ch_hit);
        acc_err = !map_ok || (apb_pwrite && is_ver);
    end

    assign apb_pready  = 1'b1;
    assign apb_pslverr = apb_psel & apb_penable & acc_err;
    assign wr_en       = apb_psel & apb_penable & apb_pwrite & ~acc_err;
    assign rd_cap      = apb_psel & ~apb_penable & ~apb_pwrite;

    // Read mux; unmapped addresses fall through to zero.
    always_comb begin
        rd_val = '0;
        if (glb_ok) begin
            case (reg_sel)
                3'd0:    rd_val[NUM_CH-1:0] = mc_en_q;
                3'd1:    rd_val[NUM_CH-1:0] = pending_q;
                3'd2:    rd_val[NUM_CH-1:0] = status_q;
                3'd3:    rd_val[NUM_CH-1:0] = mask_q;
                3'd4:    rd_val[31:0]       = VERSION;
                default: rd_val = '0;
            endcase
        end
        for (int c = 0; c < NUM_CH; c++) begin
            if (ch_hit[c]) begin
                case (reg_sel[1:0])
                    2'd0: rd_val[31:0] = {sh_q[c].trcd, sh_q[c].trp,
                                          sh_q[c].tras, sh_q[c].trc};
                    2'd1: rd_val[15:0] = {sh_q[c].trtp, sh_q[c].twr};
                    2'd2: rd_val[27:0] = sh_q[c].rf_start;
                    2'd3: rd_val[27:0] = sh_q[c].rf_period;
                    default: rd_val = '0;
                endcase
            end
        end
    end

    // Next-state terms for commit, status and apply.
    always_comb begin
        commit_set = '0;
        status_clr = '0;
        if (wr_en && glb_ok && (reg_sel == 3'd1)) begin
            commit_set = apb_pwdata[NUM_CH-1:0];
        end
        if (wr_en && glb_ok && (reg_sel == 3'd2)) begin
            status_clr = apb_pwdata[NUM_CH-1:0];
        end
        apply     = pending_q & mc_idle;
        status_nx = (status_q & ~status_clr) | mc_err_pulse;
    end

    // Global control/status state, read data capture and pulses.
    always_ff @(posedge apb_pclk or posedge apb_prst) begin
        if (apb_prst) begin
            mc_en_q        <= '0;
            pending_q      <= '0;
            status_q       <= '0;
            mask_q         <= '0;
            apb_prdata     <= '0;
            mc_cfg_updated <= '0;
            mc_irq         <= 1'b0;
        end else begin
            if (wr_en && glb_ok && (reg_sel == 3'd0)) begin
                mc_en_q <= apb_pwdata[NUM_CH-1:0];
            end
            if (wr_en && glb_ok && (reg_sel == 3'd3)) begin
                mask_q <= apb_pwdata[NUM_CH-1:0];
            end
            if (rd_cap) begin
                apb_prdata <= rd_val;
            end
            pending_q      <= (pending_q & ~apply) | commit_set;
            status_q       <= status_nx;
            mc_cfg_updated <= apply;
            mc_irq         <= |(status_nx & mask_q);
        end
    end

    // Shadow registers: software-visible copy, written by APB.
    always_ff @(posedge apb_pclk or posedge apb_prst) begin
        if (apb_prst) begin
            for (int c = 0; c < NUM_CH; c++) begin
                sh_q[c] <= TIM_RST;
            end
        end else if (wr_en) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (ch_hit[c]) begin
                    case (reg_sel[1:0])
                        2'd0: begin
                            sh_q[c].trc  <= apb_pwdata[7:0];
                            sh_q[c].tras <= apb_pwdata[15:8];
                            sh_q[c].trp  <= apb_pwdata[23:16];
                            sh_q[c].trcd <= apb_pwdata[31:24];
                        end
                        2'd1: begin
                            sh_q[c].twr  <= apb_pwdata[7:0];
                            sh_q[c].trtp <= apb_pwdata[15:8];
                        end
                        2'd2: sh_q[c].rf_start  <= apb_pwdata[27:0];
                        2'd3: sh_q[c].rf_period <= apb_pwdata[27:0];
                        default: ;
                    endcase
                end
            end
        end
    end

    // Active registers: loaded from shadow only while the channel is idle.
    always_ff @(posedge apb_pclk or posedge apb_prst) begin
        if (apb_prst) begin
            for (int c = 0; c < NUM_CH; c++) begin
                ac_q[c] <= TIM_RST;
            end
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (apply[c]) begin
                    ac_q[c] <= sh_q[c];
                end
            end
        end
    end

    // Flatten active per-channel sets onto the output buses.
    always_comb begin
        mc_trc_cfg            = '0;
        mc_tras_cfg           = '0;
        mc_trp_cfg            = '0;
        mc_trcd_cfg           = '0;
        mc_twr_cfg            = '0;
        mc_trtp_cfg           = '0;
        mc_rf_start_time_cfg  = '0;
        mc_rf_period_time_cfg = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            mc_trc_cfg[8*c +: 8]             = ac_q[c].trc;
            mc_tras_cfg[8*c +: 8]            = ac_q[c].tras;
            mc_trp_cfg[8*c +: 8]             = ac_q[c].trp;
            mc_trcd_cfg[8*c +: 8]            = ac_q[c].trcd;
            mc_twr_cfg[8*c +: 8]             = ac_q[c].twr;
            mc_trtp_cfg[8*c +: 8]            = ac_q[c].trtp;
            mc_rf_start_time_cfg[28*c +: 28]  = ac_q[c].rf_start;
            mc_rf_period_time_cfg[28*c +: 28] = ac_q[c].rf_period;
        end
    end

    assign mc_en = mc_en_q;

endmodule

// File: tb/tb_mc_apb_cfg_mch.sv
// tb_mc_apb_cfg_mch: directed self-checking bench for mc_apb_cfg_mch.
// Two channels, APB tasks, hand-computed expectations.
module tb_mc_apb_cfg_mch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        psel = 1'b0;
    logic        penable = 1'b0;
    logic        pwrite = 1'b0;
    logic [15:0] paddr = '0;
    logic [31:0] pwdata = '0;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;
    logic [1:0]  mc_idle = '0;
    logic [1:0]  mc_err_pulse = '0;
    logic [1:0]  mc_en;
    logic [15:0] trc, tras, trp, trcd, twr, trtp;
    logic [55:0] rf_start, rf_period;
    logic [1:0]  updated;
    logic        irq;

    int checks = 0;
    int failures = 0;

    logic [31:0] rd;
    logic        er;

    mc_apb_cfg_mch #(
        .APB_ADDR_WIDTH(16),
        .APB_DATA_WIDTH(32),
        .NUM_CH(2),
        .VERSION(32'h0002_0000)
    ) dut (
        .apb_pclk(clk),
        .apb_prst(rst),
        .apb_psel(psel),
        .apb_penable(penable),
        .apb_pwrite(pwrite),
        .apb_paddr(paddr),
        .apb_pwdata(pwdata),
        .apb_prdata(prdata),
        .apb_pready(pready),
        .apb_pslverr(pslverr),
        .mc_idle(mc_idle),
        .mc_err_pulse(mc_err_pulse),
        .mc_en(mc_en),
        .mc_trc_cfg(trc),
        .mc_tras_cfg(tras),
        .mc_trp_cfg(trp),
        .mc_trcd_cfg(trcd),
        .mc_twr_cfg(twr),
        .mc_trtp_cfg(trtp),
        .mc_rf_start_time_cfg(rf_start),
        .mc_rf_period_time_cfg(rf_period),
        .mc_cfg_updated(updated),
        .mc_irq(irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Write with an optional error pulse landing on the commit edge.
    task automatic apb_write(input logic [15:0] a, input logic [31:0] d,
                             input logic [1:0] pulse, output logic e);
        @(posedge clk) #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1;
        paddr = a; pwdata = d;
        @(posedge clk) #1;
        penable = 1'b1;
        mc_err_pulse = pulse;
        #1 e = pslverr;
        @(posedge clk) #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        mc_err_pulse = '0;
    endtask

    task automatic apb_read(input logic [15:0] a, output logic [31:0] d,
                            output logic e);
        @(posedge clk) #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
        @(posedge clk) #1;
        penable = 1'b1;
        #1 d = prdata;
        e = pslverr;
        @(posedge clk) #1;
        psel = 1'b0; penable = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        chk("rst_en", 64'(mc_en), 64'h0);
        chk("rst_trc", 64'(trc), 64'h1616);
        chk("rst_tras", 64'(tras), 64'h1010);
        chk("rst_trp", 64'(trp), 64'h0606);
        chk("rst_trcd", 64'(trcd), 64'h0707);
        chk("rst_twr", 64'(twr), 64'h0606);
        chk("rst_trtp", 64'(trtp), 64'h0404);
        chk("rst_rfs", 64'(rf_start), 64'hFFFFFFF_FFFFFFF);
        chk("rst_rfp", 64'(rf_period), 64'h16E3600_16E3600);
        chk("rst_prdata", 64'(prdata), 64'h0);
        chk("rst_upd", 64'(updated), 64'h0);
        chk("rst_irq", 64'(irq), 64'h0);
        chk("pready", 64'(pready), 64'h1);
        apb_read(16'h010, rd, er);
        chk("ver_rd", 64'(rd), 64'h0002_0000);
        chk("ver_err", 64'(er), 64'h0);
        apb_read(16'h104, rd, er);
        chk("t1_rst", 64'(rd), 64'h0406);

        // Shadow write and commit while busy
        apb_write(16'h100, 32'h0A09_0807, 2'b00, er);
        chk("wr_t0_err", 64'(er), 64'h0);
        apb_read(16'h100, rd, er);
        chk("shadow_rd", 64'(rd), 64'h0A09_0807);
        apb_write(16'h004, 32'h1, 2'b00, er);
        repeat (2) @(posedge clk);
        #1 chk("busy_trc", 64'(trc), 64'h1616);
        apb_read(16'h004, rd, er);
        chk("pend_rd", 64'(rd), 64'h1);

        // Apply on idle
        mc_idle = 2'b01;
        @(posedge clk) #1;
        chk("ap_trc", 64'(trc), 64'h1607);
        chk("ap_tras", 64'(tras), 64'h1008);
        chk("ap_trp", 64'(trp), 64'h0609);
        chk("ap_trcd", 64'(trcd), 64'h070A);
        chk("ap_upd", 64'(updated), 64'h1);
        @(posedge clk) #1;
        chk("ap_upd_end", 64'(updated), 64'h0);
        mc_idle = 2'b00;
        apb_read(16'h004, rd, er);
        chk("pend_clr", 64'(rd), 64'h0);

        // Error accesses
        apb_write(16'h140, 32'h1234_5678, 2'b00, er);
        chk("err_ch2", 64'(er), 64'h1);
        apb_write(16'h010, 32'h1234_5678, 2'b00, er);
        chk("err_ver_wr", 64'(er), 64'h1);
        apb_read(16'h200, rd, er);
        chk("err_rd", 64'(er), 64'h1);
        chk("err_rd_data", 64'(rd), 64'h0);
        apb_read(16'h102, rd, er);
        chk("err_misal", 64'(er), 64'h1);
        apb_read(16'h110, rd, er);
        chk("err_hole", 64'(er), 64'h1);
        apb_read(16'h010, rd, er);
        chk("ver_keep", 64'(rd), 64'h0002_0000);
        apb_read(16'h100, rd, er);
        chk("ch0_keep", 64'(rd), 64'h0A09_0807);

        // Status, mask, irq
        apb_write(16'h00C, 32'h2, 2'b00, er);
        @(posedge clk) #1 mc_err_pulse = 2'b10;
        @(posedge clk) #1 mc_err_pulse = 2'b00;
        chk("irq_set", 64'(irq), 64'h1);
        apb_read(16'h008, rd, er);
        chk("stat_set", 64'(rd), 64'h2);
        apb_write(16'h008, 32'h2, 2'b10, er);
        chk("set_wins_irq", 64'(irq), 64'h1);
        apb_read(16'h008, rd, er);
        chk("set_wins", 64'(rd), 64'h2);
        apb_write(16'h008, 32'h2, 2'b00, er);
        chk("irq_clr", 64'(irq), 64'h0);
        apb_read(16'h008, rd, er);
        chk("stat_clr", 64'(rd), 64'h0);
        @(posedge clk) #1 mc_err_pulse = 2'b01;
        @(posedge clk) #1 mc_err_pulse = 2'b00;
        chk("irq_masked", 64'(irq), 64'h0);
        apb_read(16'h008, rd, er);
        chk("stat_ch0", 64'(rd), 64'h1);

        // CTRL immediate, independent of pending/idle
        apb_write(16'h004, 32'h2, 2'b00, er);
        apb_write(16'h000, 32'h3, 2'b00, er);
        chk("ctrl_en", 64'(mc_en), 64'h3);
        apb_read(16'h004, rd, er);
        chk("pend_ch1", 64'(rd), 64'h2);

        // Reset mid-access with pending and modified shadow
        apb_write(16'h120, 32'h0102_0304, 2'b00, er);
        @(posedge clk) #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1;
        paddr = 16'h124; pwdata = 32'h0000_DEAD;
        @(posedge clk) #1;
        penable = 1'b1;
        #1 rst = 1'b1;
        #1;
        chk("mr_en", 64'(mc_en), 64'h0);
        chk("mr_trc", 64'(trc), 64'h1616);
        chk("mr_trcd", 64'(trcd), 64'h0707);
        chk("mr_prdata", 64'(prdata), 64'h0);
        @(posedge clk) #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        @(posedge clk) #1 rst = 1'b0;
        apb_read(16'h120, rd, er);
        chk("mr_sh1", 64'(rd), 64'h0706_1016);
        apb_read(16'h124, rd, er);
        chk("mr_t1", 64'(rd), 64'h0406);
        apb_read(16'h004, rd, er);
        chk("mr_pend", 64'(rd), 64'h0);
        apb_read(16'h008, rd, er);
        chk("mr_stat", 64'(rd), 64'h0);
        apb_read(16'h10C, rd, er);
        chk("mr_rfp", 64'(rd), 64'h016E_3600);

        // Multi-channel apply in one cycle
        apb_write(16'h120, 32'h0505_0505, 2'b00, er);
        apb_write(16'h100, 32'h1111_1111, 2'b00, er);
        apb_write(16'h12C, 32'h0ABC_DEF1, 2'b00, er);
        apb_write(16'h004, 32'h3, 2'b00, er);
        chk("mc_busy", 64'(trc), 64'h1616);
        mc_idle = 2'b11;
        @(posedge clk) #1;
        chk("mc_upd", 64'(updated), 64'h3);
        chk("mc_trc", 64'(trc), 64'h0511);
        chk("mc_rfp", 64'(rf_period), 64'hABCDEF1_16E3600);
        mc_idle = 2'b00;

        // Commit landing on an apply edge forces a second apply
        apb_write(16'h004, 32'h1, 2'b00, er);
        apb_write(16'h100, 32'h2222_2222, 2'b00, er);
        @(posedge clk) #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1;
        paddr = 16'h004; pwdata = 32'h1;
        @(posedge clk) #1;
        penable = 1'b1; mc_idle = 2'b01;
        @(posedge clk) #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        chk("ca_upd1", 64'(updated), 64'h1);
        chk("ca_trc", 64'(trc), 64'h0522);
        @(posedge clk) #1;
        chk("ca_upd2", 64'(updated), 64'h1);
        @(posedge clk) #1;
        chk("ca_upd3", 64'(updated), 64'h0);
        mc_idle = 2'b00;
        apb_read(16'h004, rd, er);
        chk("ca_pend", 64'(rd), 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
